// File: rtl/fft_in_pack_pkg.sv
// Shared constants, sample payload and read-FSM state encoding for the FFT input framing stage.
package fft_in_pack_pkg;

    localparam int unsigned SAMPLE_W         = 10;
    localparam int unsigned FRAME_LEN        = 64;
    localparam int unsigned WORDS_PER_FRAME  = 8;
    localparam int unsigned SAMPLES_PER_WORD = 8;
    localparam int unsigned BURST_LEN        = 8;
    localparam int unsigned HOLD_LEN         = 8;
    localparam int unsigned ADDR_W           = $clog2(FRAME_LEN);
    localparam int unsigned WIDX_W           = $clog2(WORDS_PER_FRAME);
    localparam int unsigned SLOT_W           = $clog2(SAMPLES_PER_WORD);
    localparam int unsigned CNT_W            = $clog2(BURST_LEN);
    localparam int unsigned WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;

    typedef struct packed {
        logic [SAMPLE_W-1:0] im;
        logic [SAMPLE_W-1:0] re;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BURST,
        ST_HOLD
    } rd_state_e;

    // Contiguous order reads sample 8k+j; stride-8 order reads sample k+8j.
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [WIDX_W-1:0] word,
                                                  input logic [SLOT_W-1:0] slot,
                                                  input logic transpose);
        return transpose ? ADDR_W'({slot, word}) : ADDR_W'({word, slot});
    endfunction

endpackage

// File: rtl/fft_in_pack_if.sv
// Sample-in / word-out bus of the FFT input framing stage.
interface fft_in_pack_if;
    import fft_in_pack_pkg::*;

    logic                din_valid;
    logic [SAMPLE_W-1:0] dinre;
    logic [SAMPLE_W-1:0] dinim;
    logic                din_ready;
    logic                start_count;
    logic                dout_valid;
    logic [WORD_W-1:0]   doutre;
    logic [WORD_W-1:0]   doutim;
    logic                overflow;

    modport master (
        output din_valid, dinre, dinim,
        input  din_ready, start_count, dout_valid, doutre, doutim, overflow
    );

    modport slave (
        input  din_valid, dinre, dinim,
        output din_ready, start_count, dout_valid, doutre, doutim, overflow
    );

endinterface

// File: rtl/fft_in_pack_bank.sv
// 64-sample register bank: single-sample write, 8-sample parallel read by word index.
// FFT_IN_PACK_TRANSPOSE_EN selects stride-8 read order instead of contiguous order.
module pack_bank
    import fft_in_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  sample_t           wr_data,
    input  logic [WIDX_W-1:0] rd_word,
    output logic [WORD_W-1:0] rd_re_c,
    output logic [WORD_W-1:0] rd_im_c
);

`ifdef FFT_IN_PACK_TRANSPOSE_EN
    localparam bit TRANSPOSE = 1'b1;
`else
    localparam bit TRANSPOSE = 1'b0;
`endif

    sample_t mem_q [FRAME_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_re_c = '0;
        rd_im_c = '0;
        for (int unsigned j = 0; j < SAMPLES_PER_WORD; j++) begin
            rd_re_c[j*SAMPLE_W +: SAMPLE_W] = mem_q[rd_addr(rd_word, SLOT_W'(j), TRANSPOSE)].re;
            rd_im_c[j*SAMPLE_W +: SAMPLE_W] = mem_q[rd_addr(rd_word, SLOT_W'(j), TRANSPOSE)].im;
        end
    end

endmodule

// File: rtl/fft_in_pack.sv
// FFT input framing: ping-pong 64-sample banks, each full frame sent as an 8-word burst.
// Build option FFT_IN_PACK_TRANSPOSE_EN switches the burst to stride-8 sample order.
module fft_in_pack
    import fft_in_pack_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fft_in_pack_if.slave  bus
);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              din_ready_q, din_ready_d;
    logic              start_count_q, start_count_d;
    logic              dout_valid_q, dout_valid_d;
    logic [WORD_W-1:0] doutre_q, doutre_d;
    logic [WORD_W-1:0] doutim_q, doutim_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic [1:0]        full_set, full_clr;
    logic [WORD_W-1:0] bank_re [2];
    logic [WORD_W-1:0] bank_im [2];
    sample_t           wr_sample;

    assign accept    = bus.din_valid & din_ready_q;
    assign wr_sample = '{im: bus.dinim, re: bus.dinre};

    pack_bank u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept & ~wr_bank_q),
        .wr_addr (wr_cnt_q),
        .wr_data (wr_sample),
        .rd_word (cnt_d),
        .rd_re_c (bank_re[0]),
        .rd_im_c (bank_im[0])
    );

    pack_bank u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept & wr_bank_q),
        .wr_addr (wr_cnt_q),
        .wr_data (wr_sample),
        .rd_word (cnt_d),
        .rd_re_c (bank_re[1]),
        .rd_im_c (bank_im[1])
    );

    // Fill tracking; set and clear always target different banks, so both apply.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_set  = '0;
        full_clr  = '0;
        if (accept) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
            if (wr_cnt_q == ADDR_W'(FRAME_LEN - 1)) begin
                full_set[wr_bank_q] = 1'b1;
                wr_bank_d           = ~wr_bank_q;
            end
        end
        if (state_q == ST_BURST && cnt_q == CNT_W'(BURST_LEN - 1)) begin
            full_clr[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
        end
        full_d      = (full_q & ~full_clr) | full_set;
        din_ready_d = ~full_d[wr_bank_d];
        overflow_d  = overflow_q | (bus.din_valid & ~din_ready_q);
    end

    // Read FSM next state; looks at the incoming full flag so START follows sample 63 directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (full_d[rd_bank_q]) state_d = ST_START;
            end
            ST_START: state_d = ST_BURST;
            ST_BURST: begin
                if (cnt_q == CNT_W'(BURST_LEN - 1)) state_d = ST_HOLD;
                else                                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_LEN - 1)) state_d = ST_IDLE;
                else                               cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state.
    always_comb begin
        start_count_d = 1'b0;
        dout_valid_d  = 1'b0;
        doutre_d      = '0;
        doutim_d      = '0;
        if (state_d == ST_START) start_count_d = 1'b1;
        if (state_d == ST_BURST) begin
            dout_valid_d = 1'b1;
            doutre_d     = bank_re[rd_bank_q];
            doutim_d     = bank_im[rd_bank_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            din_ready_q   <= 1'b1;
            start_count_q <= 1'b0;
            dout_valid_q  <= 1'b0;
            doutre_q      <= '0;
            doutim_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            din_ready_q   <= din_ready_d;
            start_count_q <= start_count_d;
            dout_valid_q  <= dout_valid_d;
            doutre_q      <= doutre_d;
            doutim_q      <= doutim_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.din_ready   = din_ready_q;
    assign bus.start_count = start_count_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.doutre      = doutre_q;
    assign bus.doutim      = doutim_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fft_in_pack.sv
// Directed bench for fft_in_pack: framing, burst timing, overflow and mid-burst reset.
module tb_fft_in_pack;
    import fft_in_pack_pkg::*;

`ifdef FFT_IN_PACK_TRANSPOSE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_in_pack_if bus ();

    fft_in_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          run      = 0;
    int          ready_drops = 0;
    logic [19:0] sent_q[$];
    logic [79:0] got_re_q[$];
    logic [79:0] got_im_q[$];
    int          word_cyc_q[$];
    int          start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Capture start pulses and burst words; every burst must be 8 contiguous cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (bus.start_count) start_q.push_back(cyc);
            if (bus.dout_valid) begin
                got_re_q.push_back(bus.doutre);
                got_im_q.push_back(bus.doutim);
                word_cyc_q.push_back(cyc);
                run++;
            end else if (run != 0) begin
                check("burst_len", 80'(run), 80'd8);
                run = 0;
            end
        end
    end

    function automatic logic [79:0] exp_word(input int f, input int k, input bit im);
        logic [79:0] w;
        logic [19:0] s;
        int          idx;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            idx = TR ? (k + 8 * j) : (8 * k + j);
            s   = sent_q[64 * f + idx];
            w[10*j +: 10] = im ? s[19:10] : s[9:0];
        end
        return w;
    endfunction

    task automatic clear_logs();
        sent_q.delete();
        got_re_q.delete();
        got_im_q.delete();
        word_cyc_q.delete();
        start_q.delete();
        ready_drops = 0;
    endtask

    task automatic reset_dut();
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps, input bit ramp, output int t_acc);
        logic [19:0] s;
        bit          accepted;
        int          guard;
        for (int n = 0; n < 64; n++) begin
            if (gaps) begin
                bus.din_valid = 1'b0;
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) begin
                    @(posedge clk);
                    #1;
                end
            end
            s = ramp ? {10'(-n), 10'(n)} : 20'($urandom_range(0, 20'hFFFFF));
            bus.din_valid = 1'b1;
            bus.dinre     = s[9:0];
            bus.dinim     = s[19:10];
            accepted = 1'b0;
            guard    = 0;
            while (!accepted) begin
                if (!bus.din_ready) ready_drops++;
                accepted = bus.din_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) begin
                    $display("FAIL accept_timeout: got stalled expected accept");
                    $fatal(1, "input stalled");
                end
            end
            sent_q.push_back(s);
        end
        bus.din_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_words(input int nwords);
        for (int g = 0; g < 300 && got_re_q.size() < nwords; g++) begin
            @(posedge clk);
            #1;
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic verify_frames(input int nf, input string tag);
        check($sformatf("%s_nwords", tag), 80'(got_re_q.size()), 80'(8 * nf));
        if (got_re_q.size() >= 8 * nf && sent_q.size() >= 64 * nf) begin
            for (int f = 0; f < nf; f++) begin
                for (int k = 0; k < 8; k++) begin
                    check($sformatf("%s_f%0d_w%0d_re", tag, f, k), got_re_q[8*f+k], exp_word(f, k, 1'b0));
                    check($sformatf("%s_f%0d_w%0d_im", tag, f, k), got_im_q[8*f+k], exp_word(f, k, 1'b1));
                end
            end
        end
    endtask

    int t0, t1, t2;

    initial begin
        bus.din_valid = 1'b0;
        bus.dinre     = '0;
        bus.dinim     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", 80'(bus.din_ready), 80'd1);
        check("rst_start_count", 80'(bus.start_count), 80'd0);
        check("rst_dout_valid", 80'(bus.dout_valid), 80'd0);
        check("rst_doutre", bus.doutre, 80'd0);
        check("rst_doutim", bus.doutim, 80'd0);
        check("rst_overflow", 80'(bus.overflow), 80'd0);
        reset_dut();

        // Ramp frame: re=n, im=-n
        send_frame(1'b0, 1'b1, t0);
        wait_words(8);
        check("ramp_nstart", 80'(start_q.size()), 80'd1);
        if (start_q.size() >= 1) check("ramp_start_cyc", 80'(start_q[0]), 80'(t0));
        if (word_cyc_q.size() >= 8) begin
            check("ramp_w0_cyc", 80'(word_cyc_q[0]), 80'(t0 + 1));
            check("ramp_w7_cyc", 80'(word_cyc_q[7]), 80'(t0 + 8));
        end
        verify_frames(1, "ramp");
        check("ramp_idle_re", bus.doutre, 80'd0);
        check("ramp_idle_valid", 80'(bus.dout_valid), 80'd0);

        // Three back-to-back frames under continuous input
        reset_dut();
        send_frame(1'b0, 1'b0, t0);
        send_frame(1'b0, 1'b0, t1);
        send_frame(1'b0, 1'b0, t2);
        wait_words(24);
        check("b2b_nstart", 80'(start_q.size()), 80'd3);
        if (start_q.size() >= 3) begin
            check("b2b_start0", 80'(start_q[0]), 80'(t0));
            check("b2b_gap01", 80'(start_q[1] - start_q[0]), 80'd64);
            check("b2b_gap12", 80'(start_q[2] - start_q[1]), 80'd64);
        end
        check("b2b_ready_drops", 80'(ready_drops), 80'd0);
        check("b2b_overflow", 80'(bus.overflow), 80'd0);
        verify_frames(3, "b2b");

        // Two frames with random input gaps
        reset_dut();
        send_frame(1'b1, 1'b0, t0);
        send_frame(1'b1, 1'b0, t1);
        wait_words(16);
        check("gap_nstart", 80'(start_q.size()), 80'd2);
        verify_frames(2, "gap");
        check("gap_overflow", 80'(bus.overflow), 80'd0);

        // Both banks held full: input must stall and overflow must stick
        reset_dut();
        force dut.full_q = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("ovf_ready_low", 80'(bus.din_ready), 80'd0);
        check("ovf_before", 80'(bus.overflow), 80'd0);
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ovf_set", 80'(bus.overflow), 80'd1);
        release dut.full_q;
        repeat (30) @(posedge clk);
        #1;
        check("ovf_sticky", 80'(bus.overflow), 80'd1);

        // Reset while word 4 of a burst is on the bus
        reset_dut();
        send_frame(1'b0, 1'b1, t0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_w4_valid", 80'(bus.dout_valid), 80'd1);
        check("abort_w4_re", bus.doutre, exp_word(0, 4, 1'b0));
        rst_n = 1'b0;
        #1;
        check("abort_valid", 80'(bus.dout_valid), 80'd0);
        check("abort_re", bus.doutre, 80'd0);
        check("abort_im", bus.doutim, 80'd0);
        check("abort_start", 80'(bus.start_count), 80'd0);
        check("abort_ready", 80'(bus.din_ready), 80'd1);
        reset_dut();
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_residue", 80'(start_q.size()), 80'd0);
        send_frame(1'b0, 1'b0, t0);
        wait_words(8);
        check("fresh_nstart", 80'(start_q.size()), 80'd1);
        if (start_q.size() >= 1) check("fresh_start_cyc", 80'(start_q[0]), 80'(t0));
        verify_frames(1, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
